// File: rtl/crc_checker_if.sv
// Serial CRC checker bus: payload/CRC bit streams toward the checker, frame status back.
// The timeout pulse exists only when CRC_TIMEOUT_EN is defined.
interface crc_checker_if;
  logic       data;
  logic       active;
  logic       crc_in;
  logic       crc_valid;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] err_cnt;
`ifdef CRC_TIMEOUT_EN
  logic       timeout;
`endif

  modport master (
    output data, active, crc_in, crc_valid,
    input  busy, done, error, err_cnt
`ifdef CRC_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  data, active, crc_in, crc_valid,
    output busy, done, error, err_cnt
`ifdef CRC_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/crc_checker.sv
// Serial CRC-8 frame checker: LFSR over payload bits, then compares 8 LSB-first CRC bits.
// Optional CHECK-state stall timeout is enabled by defining CRC_TIMEOUT_EN.
module crc_checker #(
  parameter logic [7:0]  SEED    = 8'hD8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  crc_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_e;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       mis_q, mis_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       busy_c;

`ifdef CRC_TIMEOUT_EN
  localparam int unsigned StallW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [StallW-1:0] stall_q, stall_d;
  logic              timeout_q, timeout_d;
  logic              stall_hit;
  assign stall_hit = (stall_q == StallW'(TIMEOUT - 1));
`endif

  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
    logic fb;
    fb = l[0] ^ d;
    return {fb, l[7] ^ fb, l[6], l[5], l[4], l[3] ^ fb, l[2], l[1]};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Active always wins; CRC_Valid only matters in CHECK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.active) state_d = DATA;
      DATA:  state_d = bus.active ? DATA : CHECK;
      CHECK: begin
        if (bus.active)                              state_d = DATA;
        else if (bus.crc_valid && bit_cnt_q == 3'd7) state_d = IDLE;
`ifdef CRC_TIMEOUT_EN
        else if (!bus.crc_valid && stall_hit)        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q != IDLE);
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    mis_d     = mis_q;
    done_d    = 1'b0;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
`ifdef CRC_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (bus.active) lfsr_d = lfsr_step(lfsr_q, bus.data);
      DATA: begin
        if (bus.active) begin
          lfsr_d = lfsr_step(lfsr_q, bus.data);
        end else begin
          bit_cnt_d = 3'd0;
          mis_d     = 1'b0;
`ifdef CRC_TIMEOUT_EN
          stall_d   = '0;
`endif
        end
      end
      CHECK: begin
        if (bus.active) begin
          // A new payload bit during CHECK aborts the frame and restarts from SEED.
          lfsr_d = lfsr_step(SEED, bus.data);
        end else if (bus.crc_valid) begin
          mis_d     = mis_q | (bus.crc_in ^ lfsr_q[0]);
          lfsr_d    = {1'b0, lfsr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef CRC_TIMEOUT_EN
          stall_d   = '0;
`endif
          if (bit_cnt_q == 3'd7) begin
            done_d  = 1'b1;
            error_d = mis_d;
            if (mis_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
`ifdef CRC_TIMEOUT_EN
        else if (stall_hit) begin
          done_d    = 1'b1;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          lfsr_d    = 8'h00;
          stall_d   = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          stall_d = stall_q + StallW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q    <= SEED;
      bit_cnt_q <= 3'd0;
      mis_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= 8'h00;
`ifdef CRC_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      mis_q     <= mis_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
`ifdef CRC_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.err_cnt = err_cnt_q;
`ifdef CRC_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`endif

endmodule
